// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, NOP word,
// register-address width and the bundle of per-cycle pipeline controls.
package pipe_pkg;

  localparam int REG_AW = 3;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    FETCH_WAIT = 3'd1,
    MEM_WAIT   = 3'd2,
    DRAIN      = 3'd3,
    HALTED     = 3'd4
  } state_t;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic ifidFlush;
    logic idexBubble;
    logic exmemEn;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// sequencer (slave). All controls are level signals sampled every cycle;
// there is no valid/ready handshake, the sequencer answers combinationally
// in the same cycle its inputs are presented.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;

  logic [REG_AW-1:0] id_rs_addr;
  logic              id_rs_valid;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rt_valid;
  logic              id_halt;
  logic [REG_AW-1:0] ex_wr_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] mem_wr_addr;
  logic              mem_reg_write;
  logic              ex_redirect;
  logic              imem_stall;
  logic              dmem_stall;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_en;
  logic              halt_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [2:0]        state_out;

  modport master (
    output id_rs_addr, id_rs_valid, id_rt_addr, id_rt_valid, id_halt,
    output ex_wr_addr, ex_reg_write, ex_mem_read, mem_wr_addr, mem_reg_write,
    output ex_redirect, imem_stall, dmem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
    input  halt_out, stall_cnt, state_out
  );

  modport slave (
    input  id_rs_addr, id_rs_valid, id_rt_addr, id_rt_valid, id_halt,
    input  ex_wr_addr, ex_reg_write, ex_mem_read, mem_wr_addr, mem_reg_write,
    input  ex_redirect, imem_stall, dmem_stall,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
    output halt_out, stall_cnt, state_out
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source/destination comparator: flags when a pending register write
// targets either source register read by the instruction in ID.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rsAddr,
  input  logic              rsValid,
  input  logic [REG_AW-1:0] rtAddr,
  input  logic              rtValid,
  input  logic [REG_AW-1:0] wrAddr,
  input  logic              wrEn,
  output logic              hit
);

  // A write only conflicts with a source that is actually read.
  always_comb begin
    hit = wrEn && ((rsValid && (rsAddr == wrAddr)) ||
                   (rtValid && (rtAddr == wrAddr)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns hazards, redirects and memory stalls into
// PC / IF/ID / ID/EX / EX/MEM controls, drains the pipe after HALT and
// counts cycles in which the PC was held.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit FWD_EN       = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t           state;
  logic [DW-1:0]    drainCnt;
  logic [CNT_W-1:0] stallCnt;
  logic             haltOut;
  logic             exHit;
  logic             memHit;
  logic             haz;
  ctrl_t            ctrl;

  hazard_cmp uExCmp (
    .rsAddr (bus.id_rs_addr),
    .rsValid(bus.id_rs_valid),
    .rtAddr (bus.id_rt_addr),
    .rtValid(bus.id_rt_valid),
    .wrAddr (bus.ex_wr_addr),
    .wrEn   (bus.ex_reg_write),
    .hit    (exHit)
  );

  hazard_cmp uMemCmp (
    .rsAddr (bus.id_rs_addr),
    .rsValid(bus.id_rs_valid),
    .rtAddr (bus.id_rt_addr),
    .rtValid(bus.id_rt_valid),
    .wrAddr (bus.mem_wr_addr),
    .wrEn   (bus.mem_reg_write),
    .hit    (memHit)
  );

  // With forwarding only a load in EX can't be bypassed in time; without it
  // every in-flight write to a source register must retire first.
  always_comb begin
    haz = (exHit && (!FWD_EN || bus.ex_mem_read)) || (!FWD_EN && memHit);
  end

  // Zero-latency pipeline controls from the current state and inputs.
  always_comb begin
    ctrl.pcEn       = 1'b1;
    ctrl.ifidEn     = 1'b1;
    ctrl.ifidFlush  = 1'b0;
    ctrl.idexBubble = 1'b0;
    ctrl.exmemEn    = 1'b1;
    case (state)
      HALTED: begin
        ctrl.pcEn       = 1'b0;
        ctrl.ifidEn     = 1'b0;
        ctrl.ifidFlush  = 1'b1;
        ctrl.idexBubble = 1'b1;
        ctrl.exmemEn    = 1'b0;
      end
      DRAIN: begin
        ctrl.pcEn       = 1'b0;
        ctrl.ifidFlush  = 1'b1;
        ctrl.idexBubble = 1'b1;
        ctrl.exmemEn    = !bus.dmem_stall;
      end
      default: begin
        if (bus.dmem_stall) begin
          ctrl.pcEn    = 1'b0;
          ctrl.ifidEn  = 1'b0;
          ctrl.exmemEn = 1'b0;
        end else if (bus.ex_redirect) begin
          ctrl.ifidFlush  = 1'b1;
          ctrl.idexBubble = 1'b1;
        end else if (haz) begin
          ctrl.pcEn       = 1'b0;
          ctrl.ifidEn     = 1'b0;
          ctrl.idexBubble = 1'b1;
        end else if (bus.imem_stall) begin
          ctrl.pcEn      = 1'b0;
          ctrl.ifidFlush = 1'b1;
        end
      end
    endcase
  end

  // Sequencer state, drain countdown, sticky halt flag and stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      drainCnt <= '0;
      stallCnt <= '0;
      haltOut  <= 1'b0;
    end else begin
      if (!ctrl.pcEn && (state != HALTED) && (stallCnt != '1))
        stallCnt <= stallCnt + 1'b1;
      case (state)
        DRAIN: begin
          if (bus.ex_redirect) begin
            state    <= RUN;
            drainCnt <= '0;
          end else if (!bus.dmem_stall) begin
            drainCnt <= drainCnt - 1'b1;
            if (drainCnt <= DW'(1)) begin
              state   <= HALTED;
              haltOut <= 1'b1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          if (bus.dmem_stall) begin
            state <= MEM_WAIT;
          end else if (bus.ex_redirect || haz) begin
            state <= RUN;
          end else if (bus.imem_stall) begin
            state <= FETCH_WAIT;
          end else if (bus.id_halt) begin
            state    <= DRAIN;
            drainCnt <= DW'(DRAIN_CYCLES);
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  assign bus.pc_en       = ctrl.pcEn;
  assign bus.ifid_en     = ctrl.ifidEn;
  assign bus.ifid_flush  = ctrl.ifidFlush;
  assign bus.idex_bubble = ctrl.idexBubble;
  assign bus.exmem_en    = ctrl.exmemEn;
  assign bus.halt_out    = haltOut;
  assign bus.stall_cnt   = stallCnt;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no forwarding / forwarding)
// driven with identical stimulus and compared to a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_MAX = 65535;
  localparam int NDRAIN  = 3;
  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}
  localparam logic [4:0] C_NORMAL = 5'b11001;
  localparam logic [4:0] C_DMEM   = 5'b00000;
  localparam logic [4:0] C_REDIR  = 5'b11111;
  localparam logic [4:0] C_HAZ    = 5'b00011;
  localparam logic [4:0] C_IMEM   = 5'b01101;

  logic       clk;
  logic       rst;
  logic [2:0] rsA, rtA, exA, memA;
  logic       rsV, rtV, halt, exW, exLd, memW, redir, imem, dmem;

  int errors = 0;
  int checks = 0;

  // behavioural model: one entry per instance (0: FWD_EN=0, 1: FWD_EN=1)
  int mState[2];
  int mDrain[2];
  int mCnt[2];
  bit mHalt[2];

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus1 ();

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .DRAIN_CYCLES(NDRAIN), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  pipe_hazard_ctrl #(.FWD_EN(1'b1), .DRAIN_CYCLES(NDRAIN), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  assign bus0.id_rs_addr    = rsA;
  assign bus0.id_rs_valid   = rsV;
  assign bus0.id_rt_addr    = rtA;
  assign bus0.id_rt_valid   = rtV;
  assign bus0.id_halt       = halt;
  assign bus0.ex_wr_addr    = exA;
  assign bus0.ex_reg_write  = exW;
  assign bus0.ex_mem_read   = exLd;
  assign bus0.mem_wr_addr   = memA;
  assign bus0.mem_reg_write = memW;
  assign bus0.ex_redirect   = redir;
  assign bus0.imem_stall    = imem;
  assign bus0.dmem_stall    = dmem;
  assign bus1.id_rs_addr    = rsA;
  assign bus1.id_rs_valid   = rsV;
  assign bus1.id_rt_addr    = rtA;
  assign bus1.id_rt_valid   = rtV;
  assign bus1.id_halt       = halt;
  assign bus1.ex_wr_addr    = exA;
  assign bus1.ex_reg_write  = exW;
  assign bus1.ex_mem_read   = exLd;
  assign bus1.mem_wr_addr   = memA;
  assign bus1.mem_reg_write = memW;
  assign bus1.ex_redirect   = redir;
  assign bus1.imem_stall    = imem;
  assign bus1.dmem_stall    = dmem;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] dut_ctl(int k);
    if (k == 0)
      return {bus0.pc_en, bus0.ifid_en, bus0.ifid_flush, bus0.idex_bubble, bus0.exmem_en};
    return {bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_bubble, bus1.exmem_en};
  endfunction

  function automatic logic [2:0] dut_state(int k);
    return (k == 0) ? bus0.state_out : bus1.state_out;
  endfunction

  function automatic logic [15:0] dut_cnt(int k);
    return (k == 0) ? bus0.stall_cnt : bus1.stall_cnt;
  endfunction

  function automatic logic dut_halt(int k);
    return (k == 0) ? bus0.halt_out : bus1.halt_out;
  endfunction

  // ---- reference model ----
  function automatic bit hazard(int k);
    bit exHit;
    bit memHit;
    exHit  = exW && ((rsV && rsA == exA) || (rtV && rtA == exA));
    memHit = memW && ((rsV && rsA == memA) || (rtV && rtA == memA));
    if (k == 0) return exHit || memHit;
    return exHit && exLd;
  endfunction

  function automatic logic [4:0] exp_ctl(int k);
    if (mState[k] == 4) return 5'b00110;
    if (mState[k] == 3) return {4'b0111, ~dmem};
    if (dmem)           return C_DMEM;
    if (redir)          return C_REDIR;
    if (hazard(k))      return C_HAZ;
    if (imem)           return C_IMEM;
    return C_NORMAL;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] c;
      c = exp_ctl(k);
      if (!rst) begin
        mState[k] = 0; mDrain[k] = 0; mCnt[k] = 0; mHalt[k] = 0;
      end else begin
        if (!c[4] && mState[k] != 4 && mCnt[k] < CNT_MAX) mCnt[k]++;
        if (mState[k] == 3) begin
          if (redir) begin
            mState[k] = 0; mDrain[k] = 0;
          end else if (!dmem) begin
            mDrain[k]--;
            if (mDrain[k] == 0) begin mState[k] = 4; mHalt[k] = 1; end
          end
        end else if (mState[k] != 4) begin
          if (dmem)                      mState[k] = 2;
          else if (redir || hazard(k))   mState[k] = 0;
          else if (imem)                 mState[k] = 1;
          else if (halt) begin mState[k] = 3; mDrain[k] = NDRAIN; end
          else                           mState[k] = 0;
        end
      end
    end
  endtask

  // ---- driver tasks ----
  task automatic clear_inputs();
    rst = 1'b1;
    rsA = '0; rtA = '0; exA = '0; memA = '0;
    rsV = 0; rtV = 0; halt = 0; exW = 0; exLd = 0; memW = 0;
    redir = 0; imem = 0; dmem = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_state(k) !== 3'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d want 0", k, dut_state(k)); end
      checks++;
      if (dut_cnt(k) !== 16'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d want 0", k, dut_cnt(k)); end
      checks++;
      if (dut_halt(k) !== 1'b0) begin errors++; $display("FAIL reset_halt[%0d]: got %b want 0", k, dut_halt(k)); end
      checks++;
      if (dut_ctl(k) !== C_NORMAL) begin errors++; $display("FAIL reset_ctl[%0d]: got %b want %b", k, dut_ctl(k), C_NORMAL); end
    end
  endtask

  task automatic test_raw();
    do_reset();
    rsA = 3'd3; rsV = 1; exA = 3'd3; exW = 1; exLd = 0;
    #1;
    checks++;
    if (dut_ctl(0) !== C_HAZ) begin errors++; $display("FAIL raw_nofwd_ctl: got %b want %b", dut_ctl(0), C_HAZ); end
    checks++;
    if (dut_ctl(1) !== C_NORMAL) begin errors++; $display("FAIL raw_fwd_ctl: got %b want %b", dut_ctl(1), C_NORMAL); end
    tick();
    checks++;
    if (dut_cnt(0) !== 16'd1) begin errors++; $display("FAIL raw_nofwd_cnt: got %0d want 1", dut_cnt(0)); end
    checks++;
    if (dut_cnt(1) !== 16'd0) begin errors++; $display("FAIL raw_fwd_cnt: got %0d want 0", dut_cnt(1)); end
  endtask

  task automatic test_load_use();
    do_reset();
    exLd = 1; exW = 1; exA = 3'd5; rtA = 3'd5; rtV = 1;
    #1;
    checks++;
    if (dut_ctl(1) !== C_HAZ) begin errors++; $display("FAIL loaduse_stall: got %b want %b", dut_ctl(1), C_HAZ); end
    tick();
    // bubble now in EX, load has moved on to MEM
    exLd = 0; exW = 0; memW = 1; memA = 3'd5;
    #1;
    checks++;
    if (dut_ctl(1) !== C_NORMAL) begin errors++; $display("FAIL loaduse_release: got %b want %b", dut_ctl(1), C_NORMAL); end
    checks++;
    if (dut_cnt(1) !== 16'd1) begin errors++; $display("FAIL loaduse_cnt: got %0d want 1", dut_cnt(1)); end
    tick();
    checks++;
    if (dut_cnt(1) !== 16'd1) begin errors++; $display("FAIL loaduse_cnt_hold: got %0d want 1", dut_cnt(1)); end
  endtask

  task automatic test_redirect_haz();
    do_reset();
    rsA = 3'd2; rsV = 1; exA = 3'd2; exW = 1; exLd = 1; redir = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== C_REDIR) begin errors++; $display("FAIL redir_haz_ctl[%0d]: got %b want %b", k, dut_ctl(k), C_REDIR); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_cnt(k) !== 16'd0 || dut_state(k) !== 3'd0) begin
        errors++; $display("FAIL redir_haz_after[%0d]: got cnt=%0d st=%0d want cnt=0 st=0", k, dut_cnt(k), dut_state(k));
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt = 1;
    tick();
    halt = 0;
    for (int i = 0; i < NDRAIN; i++) begin
      checks++;
      if (dut_state(0) !== 3'd3 || bus0.pc_en !== 1'b0 || bus0.halt_out !== 1'b0) begin
        errors++; $display("FAIL halt_drain%0d: got st=%0d pc=%b h=%b want st=3 pc=0 h=0", i, dut_state(0), bus0.pc_en, bus0.halt_out);
      end
      tick();
    end
    checks++;
    if (dut_state(0) !== 3'd4 || bus0.halt_out !== 1'b1) begin
      errors++; $display("FAIL halt_done: got st=%0d h=%b want st=4 h=1", dut_state(0), bus0.halt_out);
    end
    tick();
    tick();
    checks++;
    if (dut_state(1) !== 3'd4 || bus1.halt_out !== 1'b1 || bus1.pc_en !== 1'b0 || dut_cnt(1) !== 16'd3) begin
      errors++; $display("FAIL halt_sticky: got st=%0d h=%b pc=%b cnt=%0d want st=4 h=1 pc=0 cnt=3",
                         dut_state(1), bus1.halt_out, bus1.pc_en, dut_cnt(1));
    end
    // wrong-path HALT: redirect during the second drain cycle
    do_reset();
    halt = 1;
    tick();
    halt = 0;
    tick();
    redir = 1;
    tick();
    redir = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_state(k) !== 3'd0 || dut_halt(k) !== 1'b0) begin
        errors++; $display("FAIL halt_redirect[%0d]: got st=%0d h=%b want st=0 h=0", k, dut_state(k), dut_halt(k));
      end
    end
    repeat (4) tick();
    checks++;
    if (bus0.halt_out !== 1'b0 || bus0.state_out !== 3'd0) begin
      errors++; $display("FAIL halt_redirect_later: got st=%0d h=%b want st=0 h=0", bus0.state_out, bus0.halt_out);
    end
  endtask

  task automatic test_dmem_imem();
    do_reset();
    dmem = 1; imem = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dut_ctl(0) !== C_DMEM) begin errors++; $display("FAIL dmem_ctl%0d: got %b want %b", i, dut_ctl(0), C_DMEM); end
      tick();
      checks++;
      if (dut_state(1) !== 3'd2) begin errors++; $display("FAIL dmem_state%0d: got %0d want 2", i, dut_state(1)); end
    end
    dmem = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (dut_ctl(1) !== C_IMEM) begin errors++; $display("FAIL imem_ctl%0d: got %b want %b", i, dut_ctl(1), C_IMEM); end
      tick();
      checks++;
      if (dut_state(0) !== 3'd1) begin errors++; $display("FAIL imem_state%0d: got %0d want 1", i, dut_state(0)); end
    end
    imem = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_state(k) !== 3'd0 || dut_cnt(k) !== 16'd6) begin
        errors++; $display("FAIL stall_total[%0d]: got st=%0d cnt=%0d want st=0 cnt=6", k, dut_state(k), dut_cnt(k));
      end
    end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    dmem = 1;
    repeat (CNT_MAX + 5) tick();
    checks++;
    if (bus0.stall_cnt !== 16'hFFFF || bus0.state_out !== 3'd2) begin
      errors++; $display("FAIL saturate: got cnt=%h st=%0d want cnt=ffff st=2", bus0.stall_cnt, bus0.state_out);
    end
    rst = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_state(k) !== 3'd0 || dut_cnt(k) !== 16'd0 || dut_halt(k) !== 1'b0) begin
        errors++; $display("FAIL sat_reset[%0d]: got st=%0d cnt=%0d h=%b want 0/0/0", k, dut_state(k), dut_cnt(k), dut_halt(k));
      end
    end
    rst = 1;
    dmem = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 49) != 0);
      rsA   = 3'($urandom_range(0, 7));
      rtA   = 3'($urandom_range(0, 7));
      exA   = 3'($urandom_range(0, 7));
      memA  = 3'($urandom_range(0, 7));
      rsV   = 1'($urandom_range(0, 1));
      rtV   = 1'($urandom_range(0, 1));
      exW   = 1'($urandom_range(0, 1));
      exLd  = ($urandom_range(0, 3) == 0);
      memW  = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 7) == 0);
      imem  = ($urandom_range(0, 4) == 0);
      dmem  = ($urandom_range(0, 5) == 0);
      halt  = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_ctl(k) !== exp_ctl(k)) begin
          errors++; $display("FAIL rand_ctl[%0d] n=%0d: got %b want %b", k, n, dut_ctl(k), exp_ctl(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_state(k) !== 3'(mState[k]) || dut_cnt(k) !== 16'(mCnt[k]) || dut_halt(k) !== mHalt[k]) begin
          errors++; $display("FAIL rand_reg[%0d] n=%0d: got st=%0d cnt=%0d h=%b want st=%0d cnt=%0d h=%b",
                             k, n, dut_state(k), dut_cnt(k), dut_halt(k), mState[k], mCnt[k], mHalt[k]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_load_use();
    test_redirect_haz();
    test_halt();
    test_dmem_imem();
    test_saturate_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
